// File: rtl/jtag_shift_master_if.sv
// Command/response and JTAG pin bundle for the TCK-domain JTAG host engine.
interface jtag_shift_master_if #(
    parameter int IR_WIDTH = 4,
    parameter int DR_WIDTH = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                cmd_ir_only;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic                busy;
    logic                tck;
    logic                tms;
    logic                tdi;
    logic                tdo;

    // master: the shift engine itself; slave: the command issuer plus the TAP.
    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, tdo,
        output cmd_ready, rsp_valid, rsp_dr, busy, tck, tms, tdi
    );
    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, tdo,
        input  cmd_ready, rsp_valid, rsp_dr, busy, tck, tms, tdi
    );
endinterface

// File: rtl/jtag_shift_master.sv
// JTAG host engine: one IR scan, optional DR scan, return to Run-Test/Idle,
// report the captured DR bits.
module jtag_shift_master #(
    parameter int IR_WIDTH = 4,
    parameter int DR_WIDTH = 32,
    parameter int TCK_DIV  = 4
) (
    input  logic               clk,
    input  logic               reset,
    jtag_shift_master_if.master bus
);
    // state      | meaning
    // INIT_TLR   | 5x tms=1 then tms=0: force TAP to Run-Test/Idle
    // IDLE       | wait for command, tck parked low
    // IR_HDR     | tms 1,1,0,0 into Shift-IR
    // IR_SHIFT   | shift instruction LSB first, last bit exits
    // IR_TAIL    | Update-IR, Run-Test/Idle
    // DR_HDR     | tms 1,0,0 into Shift-DR
    // DR_SHIFT   | shift data LSB first, capture tdo
    // DR_TAIL    | Update-DR, Run-Test/Idle
    // DONE       | one-clk response pulse
    localparam int CNT_MAX = (DR_WIDTH > 6) ? DR_WIDTH : 6;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int DW      = $clog2(TCK_DIV);

    typedef enum logic [3:0] {
        S_INIT_TLR, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL,
        S_DR_HDR, S_DR_SHIFT, S_DR_TAIL, S_DONE
    } state_t;

    state_t              state_q, state_d, state_after;
    logic [CW-1:0]       bit_q, bit_d, last_bit;
    logic [DW-1:0]       div_q, div_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_q, ir_sel;
    logic [DR_WIDTH-1:0] dr_q, dr_sel, cap_q, rsp_dr_q;
    logic                ir_only_q;
    logic                ticking, wrap, tck_fall, tck_rise, accept;

    assign ticking  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign wrap     = (div_q == DW'(TCK_DIV - 1));
    assign tck_fall = ticking && wrap && tck_q;
    assign tck_rise = ticking && wrap && !tck_q;
    assign accept   = (state_q == S_IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT_TLR;
            bit_q   <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        last_bit    = '0;
        state_after = S_IDLE;
        div_d       = '0;
        tck_d       = 1'b0;
        case (state_q)
            S_INIT_TLR: begin last_bit = CW'(5);            state_after = S_IDLE;     end
            S_IR_HDR:   begin last_bit = CW'(3);            state_after = S_IR_SHIFT; end
            S_IR_SHIFT: begin last_bit = CW'(IR_WIDTH - 1); state_after = S_IR_TAIL;  end
            S_IR_TAIL:  begin
                last_bit    = CW'(1);
                state_after = ir_only_q ? S_DONE : S_DR_HDR;
            end
            S_DR_HDR:   begin last_bit = CW'(2);            state_after = S_DR_SHIFT; end
            S_DR_SHIFT: begin last_bit = CW'(DR_WIDTH - 1); state_after = S_DR_TAIL;  end
            S_DR_TAIL:  begin last_bit = CW'(1);            state_after = S_DONE;     end
            default: ;
        endcase

        if (ticking) begin
            div_d = wrap ? '0 : div_q + DW'(1);
            tck_d = wrap ? ~tck_q : tck_q;
        end

        case (state_q)
            S_IDLE: if (accept) state_d = S_IR_HDR;
            S_DONE: state_d = S_IDLE;
            default: begin
                if (tck_fall) begin
                    if (bit_q == last_bit) begin
                        state_d = state_after;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // tms/tdi are computed for the upcoming bit so they change with the tck fall.
    always_comb begin
        ir_sel = ir_q >> bit_d;
        dr_sel = dr_q >> bit_d;
        tms_d  = 1'b0;
        tdi_d  = 1'b0;
        case (state_d)
            S_INIT_TLR: tms_d = (bit_d != CW'(5));
            S_IR_HDR:   tms_d = (bit_d < CW'(2));
            S_IR_SHIFT: begin
                tms_d = (bit_d == CW'(IR_WIDTH - 1));
                tdi_d = ir_sel[0];
            end
            S_IR_TAIL, S_DR_HDR, S_DR_TAIL: tms_d = (bit_d == '0);
            S_DR_SHIFT: begin
                tms_d = (bit_d == CW'(DR_WIDTH - 1));
                tdi_d = dr_sel[0];
            end
            default: ;
        endcase
        bus.cmd_ready = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.rsp_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            dr_q      <= '0;
            ir_only_q <= 1'b0;
            cap_q     <= '0;
            rsp_dr_q  <= '0;
        end else begin
            if (accept) begin
                ir_q      <= bus.cmd_ir;
                dr_q      <= bus.cmd_dr;
                ir_only_q <= bus.cmd_ir_only;
            end
            // tdo changed on the previous tck fall, so it is stable here.
            if (tck_rise && state_q == S_DR_SHIFT)
                cap_q <= {bus.tdo, cap_q[DR_WIDTH-1:1]};
            if (state_d == S_DONE)
                rsp_dr_q <= ir_only_q ? '0 : cap_q;
        end
    end

    assign bus.tck    = tck_q;
    assign bus.tms    = tms_q;
    assign bus.tdi    = tdi_q;
    assign bus.rsp_dr = rsp_dr_q;
endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master against a small behavioural TAP
// (IDCODE=1, READREG=2, SETREGISTER=3, BYPASS=F).
module tb_jtag_shift_master;
    localparam int IRW = 4;
    localparam int DRW = 32;
    localparam logic [31:0] IDCODE = 32'h100011d3;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tck_cnt  = 0;
    int   rsp_cnt  = 0;
    logic tms_log [0:1023];
    logic tdi_log [0:1023];

    jtag_shift_master_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus ();

    jtag_shift_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge bus.tck) begin
        tms_log[tck_cnt] <= bus.tms;
        tdi_log[tck_cnt] <= bus.tdi;
        tck_cnt          <= tck_cnt + 1;
    end

    always @(posedge clk) if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;

    // Behavioural TAP
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR, T_EX2_DR, T_UPD_DR,
        T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR, T_EX2_IR, T_UPD_IR
    } tap_t;
    tap_t        tap_st   = T_TLR;
    logic [3:0]  tap_ir   = 4'h1;
    logic [3:0]  ir_sh    = 4'h0;
    logic [31:0] dr_sh    = 32'h0;
    logic [31:0] user_reg = 32'hCAFEF00D;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:    return m ? T_TLR    : T_RTI;
            T_RTI:    return m ? T_SEL_DR : T_RTI;
            T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
            T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
            T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
            T_EX1_DR: return m ? T_UPD_DR : T_PAU_DR;
            T_PAU_DR: return m ? T_EX2_DR : T_PAU_DR;
            T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
            T_UPD_DR: return m ? T_SEL_DR : T_RTI;
            T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
            T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
            T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
            T_EX1_IR: return m ? T_UPD_IR : T_PAU_IR;
            T_PAU_IR: return m ? T_EX2_IR : T_PAU_IR;
            T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
            default:  return m ? T_SEL_DR : T_RTI;
        endcase
    endfunction

    always @(posedge bus.tck) begin
        case (tap_st)
            T_TLR:    tap_ir <= 4'h1;
            T_CAP_IR: ir_sh <= 4'b0001;
            T_SH_IR:  ir_sh <= {bus.tdi, ir_sh[3:1]};
            T_UPD_IR: tap_ir <= ir_sh;
            T_CAP_DR: begin
                case (tap_ir)
                    4'h1:       dr_sh <= IDCODE;
                    4'h2, 4'h3: dr_sh <= user_reg;
                    default:    dr_sh <= 32'h0;
                endcase
            end
            T_SH_DR:  dr_sh <= (tap_ir == 4'hF) ? {31'b0, bus.tdi} : {bus.tdi, dr_sh[31:1]};
            T_UPD_DR: if (tap_ir == 4'h3) user_reg <= dr_sh;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, bus.tms);
    end

    always @(negedge bus.tck) begin
        if (tap_st == T_SH_IR)      bus.tdo <= ir_sh[0];
        else if (tap_st == T_SH_DR) bus.tdo <= dr_sh[0];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] log_word(input int base, input int n, input bit use_tdi);
        logic [63:0] w = '0;
        for (int i = 0; i < n && i < 64; i++) w[i] = use_tdi ? tdi_log[base + i] : tms_log[base + i];
        return w;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            n++;
            if (bus.cmd_ready) break;
        end
    endtask

    task automatic run_cmd(input logic [3:0] ir, input logic [31:0] dr, input logic ir_only,
                           output int ntck, output logic [31:0] rsp, output int base);
        int  n;
        bit  seen = 0;
        wait_ready(n);
        bus.cmd_valid   = 1'b1;
        bus.cmd_ir      = ir;
        bus.cmd_dr      = dr;
        bus.cmd_ir_only = ir_only;
        base = tck_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rsp = '0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_val("rsp_seen", 32'(seen), 32'd1);
        rsp  = bus.rsp_dr;
        ntck = tck_cnt - base;
        @(negedge clk);
        check_val("rsp_pulse_1clk", 32'(bus.rsp_valid), 32'd0);
        check_val("ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int          n, ntck, base, viol, rc0;
        logic [31:0] rsp, rsp1;

        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_ir      = '0;
        bus.cmd_dr      = '0;
        bus.cmd_ir_only = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tck", 32'(bus.tck), 32'd0);
        check_val("rst_tms", 32'(bus.tms), 32'd1);
        check_val("rst_tdi", 32'(bus.tdi), 32'd0);
        check_val("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd1);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_dr", bus.rsp_dr, 32'd0);

        // Initial Test-Logic-Reset walk
        reset = 1'b0;
        wait_ready(n);
        check_val("tlr_clks", 32'(n), 32'd48);
        check_val("tlr_tcks", 32'(tck_cnt), 32'd6);
        check_val("tlr_tms", log_word(0, 6, 0)[31:0], 32'h1F);
        check_val("idle_busy", 32'(bus.busy), 32'd0);
        check_val("idle_tms", 32'(bus.tms), 32'd0);

        // IR-only scan
        run_cmd(4'b0001, 32'h0, 1'b1, ntck, rsp, base);
        check_val("iro_tcks", 32'(ntck), 32'd10);
        check_val("iro_tms", log_word(base, 10, 0)[31:0], 32'h183);
        check_val("iro_tdi", log_word(base, 10, 1)[31:0], 32'h010);
        check_val("iro_rsp", rsp, 32'h0);
        check_val("iro_tck_low", 32'(bus.tck), 32'd0);

        // IDCODE
        run_cmd(4'h1, 32'h0, 1'b0, ntck, rsp, base);
        check_val("idc_tcks", 32'(ntck), 32'd47);
        check_val("idc_rsp", rsp, IDCODE);
        check_val("idc_tap_rti", 32'(tap_st), 32'(T_RTI));

        // BYPASS
        run_cmd(4'hF, 32'hA5A5A5A5, 1'b0, ntck, rsp, base);
        check_val("byp_tcks", 32'(ntck), 32'd47);
        check_val("byp_rsp", rsp, 32'h4B4B4B4A);

        // Back-to-back: SETREGISTER then READREG with cmd_valid held
        wait_ready(n);
        rc0 = rsp_cnt;
        viol = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_ir      = 4'h3;
        bus.cmd_dr      = 32'h12345678;
        bus.cmd_ir_only = 1'b0;
        @(negedge clk);
        bus.cmd_ir = 4'h2;
        bus.cmd_dr = 32'h0;
        for (int i = 0; i < 2000 && !bus.rsp_valid; i++) begin
            if (bus.cmd_ready) viol++;
            @(negedge clk);
        end
        rsp1 = bus.rsp_dr;
        @(negedge clk);
        check_val("b2b_idle_dwell", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        check_val("b2b_second_accept", 32'(bus.busy), 32'd1);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && !bus.rsp_valid; i++) begin
            if (bus.cmd_ready) viol++;
            @(negedge clk);
        end
        check_val("b2b_rsp1", rsp1, 32'hCAFEF00D);
        check_val("b2b_rsp2", bus.rsp_dr, 32'h12345678);
        @(negedge clk);
        check_val("b2b_ready_low", 32'(viol), 32'd0);
        check_val("b2b_rsp_count", 32'(rsp_cnt - rc0), 32'd2);

        // Reset during DR_SHIFT bit 15 (29th rising tck of the command)
        wait_ready(n);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = 4'h1;
        bus.cmd_dr    = 32'h0;
        base = tck_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && (tck_cnt - base) < 29; i++) @(negedge clk);
        check_val("mid_tcks", 32'(tck_cnt - base), 32'd29);
        rc0 = rsp_cnt;
        @(negedge clk);
        check_val("mid_tck_high", 32'(bus.tck), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_tck", 32'(bus.tck), 32'd0);
        check_val("mid_rst_tms", 32'(bus.tms), 32'd1);
        check_val("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = tck_cnt;
        wait_ready(n);
        check_val("mid_tlr_clks", 32'(n), 32'd48);
        check_val("mid_tlr_tcks", 32'(tck_cnt - base), 32'd6);
        check_val("mid_tlr_tms", log_word(base, 6, 0)[31:0], 32'h1F);
        check_val("mid_no_rsp", 32'(rsp_cnt - rc0), 32'd0);

        run_cmd(4'h1, 32'h0, 1'b0, ntck, rsp, base);
        check_val("post_idc_rsp", rsp, IDCODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_shift_master.md
Name: jtag_shift_master

Overview:
- TCK-domain JTAG host engine. It drives TCK/TMS/TDI into a TAP, such as the vJTAG responder in the board design or the device pins, and samples TDO.
- Each accepted command performs one IR scan, optionally followed by one DR scan, then returns to Run-Test/Idle and reports the captured DR bits.
- Lets on-chip or bench logic issue the same opcodes (IDCODE, SETREGISTER, READREG, RESETHI/LO, ...) that the host PC sends.

Parameters:
- IR_WIDTH, 4, instruction register length in bits.
- DR_WIDTH, 32, data register length in bits.
- TCK_DIV, 4, clk cycles per TCK half-period; legal range >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  instruction to shift, LSB first.
- cmd_dr  in  DR_WIDTH  data to shift, LSB first.
- cmd_ir_only  in  1  when 1, skip the DR scan.
- rsp_valid  out  1  one-clk pulse when a command completes.
- rsp_dr  out  DR_WIDTH  captured TDO bits; held until the next rsp_valid.
- busy  out  1  high in every state except IDLE.
- tck  out  1  JTAG clock; idles low.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to the TAP.
- tdo  in  1  JTAG data from the TAP.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_dr=0. State is INIT_TLR, bit counter 0, divider 0.
- TCK generation:
  - A divider counts 0..TCK_DIV-1. On wrap, tck toggles.
  - Each TCK bit lasts 2*TCK_DIV clks.
  - tck toggles only outside IDLE.
- Edge rules:
  - tms/tdi update in the same clk cycle tck goes 1->0.
  - The first bit of a sequence is driven on the command-accept cycle, before the first rising edge.
  - tdo is registered in the clk cycle tck goes 0->1. No synchronizer is needed because tdo is stable a full half-period before sampling.
- INIT_TLR: 5 TCKs with tms=1, then 1 TCK with tms=0 (6 TCKs total), leaving the TAP in Run-Test/Idle. Then go to IDLE. This sequence runs after every reset deassertion.
- IDLE: tck=0, tms=0, cmd_ready=1, busy=0. On accept, latch cmd_ir, cmd_dr and cmd_ir_only, and go to IR_HDR.
- IR_HDR: tms 1,1,0,0 over 4 TCKs (Select-DR, Select-IR, Capture-IR, Shift-IR); tdi=0.
- IR_SHIFT: IR_WIDTH TCKs, tdi = cmd_ir[i] LSB first. tms=0 on every bit except the last, which has tms=1 (Exit1-IR). TDO during IR shift is discarded.
- IR_TAIL: tms 1 then 0 (Update-IR, Run-Test/Idle). Then:
  - if ir_only, go to DONE with rsp_dr=0;
  - otherwise go to DR_HDR.
- DR_HDR: tms 1,0,0 over 3 TCKs (Select-DR, Capture-DR, Shift-DR).
- DR_SHIFT: DR_WIDTH TCKs, tdi = cmd_dr[i] LSB first, last bit has tms=1. Each sampled tdo shifts into the capture register at the MSB end (right shift), so after DR_WIDTH bits the first sampled bit sits at bit 0.
- DR_TAIL: tms 1 then 0 (Update-DR, Run-Test/Idle).
- DONE: one clk with tck=0. rsp_valid=1 and rsp_dr=capture register. Next state is IDLE.
- TCK counts per command: IR-only = 6+IR_WIDTH (10 at defaults); IR+DR = 11+IR_WIDTH+DR_WIDTH (47 at defaults).
- tck ends each command low. cmd_ready rises the clk after rsp_valid.
- Back-to-back: cmd_valid held high is accepted on the first IDLE cycle. The minimum IDLE dwell is 1 clk.
- cmd_valid and all cmd_* inputs are ignored while busy; latched copies are used.
- Reset mid-operation: all outputs return to reset values immediately and asynchronously. No rsp_valid is produced for the aborted command. INIT_TLR reruns after deassertion because the TAP state is unknown.
- Counters: the bit counter is sized for max(DR_WIDTH, 6). It is cleared on each state change and never wraps within a state.

Test Plan:
- Release reset, TCK_DIV=4 -> exactly 6 tck rising edges with tms=1,1,1,1,1,0. First cmd_ready=1 occurs 48 clks + tail after deassert; busy=0 from then.
- cmd_ir=4'b0001, cmd_ir_only=1 -> 10 TCKs. tms=1,1,0,0,0,0,0,1,1,0; tdi in shift bits=1,0,0,0; rsp_valid pulse with rsp_dr=0.
- IDCODE: cmd_ir=1, cmd_dr=0, TAP model returns 32'h100011d3 -> 47 TCKs; rsp_dr=32'h100011d3.
- BYPASS: TAP model loops tdi->tdo with one-bit delay, cmd_ir=4'hF, cmd_dr=32'hA5A5A5A5 -> rsp_dr=32'h4B4B4B4A (data shifted by one, first bit = bypass 0).
- Back-to-back: cmd_valid held with SETREGISTER(3) then READREG(2) -> two rsp_valid pulses. cmd_ready low throughout each scan; inputs changed mid-scan do not alter tdi.
- Assert reset during DR_SHIFT bit 15 -> tck=0 and tms=1 the same cycle; no rsp_valid; after release, the 6-TCK TLR sequence repeats before cmd_ready=1.
